// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, data word and grant owner encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // core selects the requesting core, is_d selects dcache (1) or icache (0)
  typedef struct packed {
    logic core;
    logic is_d;
  } owner_t;

  localparam owner_t OWNER_RESET = '{core: 1'b0, is_d: 1'b0};

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick among pending requesters, rotated by the round-robin pointer.
module mem_arb_pick
  import cpu_types_pkg::*;
(
  input  logic d_req [2],
  input  logic i_req [2],
  input  logic rr,
  output logic valid,
  output logic core,
  output logic is_d
);

  // dcache beats icache so writebacks and fills are not stalled behind fetches
  always_comb begin
    valid = 1'b1;
    core  = rr;
    is_d  = 1'b1;
    if (d_req[rr]) begin
      core = rr;
      is_d = 1'b1;
    end else if (d_req[~rr]) begin
      core = ~rr;
      is_d = 1'b1;
    end else if (i_req[rr]) begin
      core = rr;
      is_d = 1'b0;
    end else if (i_req[~rr]) begin
      core = ~rr;
      is_d = 1'b0;
    end else begin
      valid = 1'b0;
      core  = 1'b0;
      is_d  = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for per-core icache/dcache requesters with a locked grant.
//   state | meaning
//   IDLE  | no owner; arbitrate pending requests, all waits high
//   OWNED | owner drives the RAM until it drops all of its requests
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN     [CPUS],
  input  word_t     iaddr    [CPUS],
  input  logic      dREN     [CPUS],
  input  logic      dWEN     [CPUS],
  input  word_t     daddr    [CPUS],
  input  word_t     dstore   [CPUS],
  output logic      iwait    [CPUS],
  output logic      dwait    [CPUS],
  output word_t     iload    [CPUS],
  output word_t     dload    [CPUS],
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0] state_q, state_d;
  owner_t     owner_q, owner_d;
  logic       rr_q, rr_d;

  logic d_req [CPUS];
  logic pick_valid, pick_core, pick_is_d;
  logic owner_req;

  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      d_req[c] = dREN[c] | dWEN[c];
    end
  end

  mem_arb_pick u_pick (
    .d_req (d_req),
    .i_req (iREN),
    .rr    (rr_q),
    .valid (pick_valid),
    .core  (pick_core),
    .is_d  (pick_is_d)
  );

  assign owner_req = owner_q.is_d ? d_req[owner_q.core] : iREN[owner_q.core];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (state_q == IDLE) begin
      if (pick_valid) begin
        state_d = OWNED;
        owner_d = '{core: pick_core, is_d: pick_is_d};
      end
    end else if (!owner_req) begin
      // a request arriving now waits for the next IDLE cycle, giving the other core a turn
      state_d = IDLE;
      rr_d    = ~owner_q.core;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= OWNER_RESET;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      iwait[c] = 1'b1;
      dwait[c] = 1'b1;
      iload[c] = '0;
      dload[c] = '0;
    end
    if (state_q == OWNED) begin
      if (owner_q.is_d) begin
        // a simultaneous read and write from the owner resolves to the write
        ramWEN                = dWEN[owner_q.core];
        ramREN                = dREN[owner_q.core] & ~dWEN[owner_q.core];
        ramaddr               = daddr[owner_q.core];
        ramstore              = dstore[owner_q.core];
        dwait[owner_q.core]   = (ramstate != ACCESS);
        dload[owner_q.core]   = ramload;
      end else begin
        ramREN                = iREN[owner_q.core];
        ramaddr               = iaddr[owner_q.core];
        iwait[owner_q.core]   = (ramstate != ACCESS);
        iload[owner_q.core]   = ramload;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle model compare plus directed scenarios.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN [2];
  word_t     iaddr [2];
  logic      dREN [2];
  logic      dWEN [2];
  word_t     daddr [2];
  word_t     dstore [2];
  logic      iwait [2];
  logic      dwait [2];
  word_t     iload [2];
  word_t     dload [2];
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(2)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model: who holds the RAM, which port, and whose turn it is
  bit m_own, m_core, m_isd, m_rr;

  function automatic bit wants(input bit isd, input bit c);
    return isd ? (dREN[c] | dWEN[c]) : iREN[c];
  endfunction

  // returns {found, is_d, core}: dcache of the favoured core, other dcache, then icaches
  function automatic logic [2:0] model_pick(input bit rr);
    logic [2:0] r;
    bit isd, c;
    r = 3'b000;
    for (int k = 0; k < 4; k++) begin
      isd = (k < 2);
      c   = (k % 2 == 0) ? rr : !rr;
      if (!r[2] && wants(isd, c)) r = {1'b1, isd, c};
    end
    return r;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_own  <= 1'b0;
      m_core <= 1'b0;
      m_isd  <= 1'b0;
      m_rr   <= 1'b0;
    end else if (!m_own) begin
      if (model_pick(m_rr) >= 3'b100) begin
        m_own  <= 1'b1;
        m_isd  <= model_pick(m_rr) >= 3'b110;
        m_core <= model_pick(m_rr) % 2 == 1;
      end
    end else if (!wants(m_isd, m_core)) begin
      m_own <= 1'b0;
      m_rr  <= !m_core;
    end
  end

  always @(negedge CLK) begin
    logic  e_ren, e_wen;
    word_t e_addr, e_store;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = '0;
    e_store = '0;
    if (m_own && m_isd) begin
      e_wen   = dWEN[m_core];
      e_ren   = dREN[m_core] && !dWEN[m_core];
      e_addr  = daddr[m_core];
      e_store = dstore[m_core];
    end else if (m_own) begin
      e_ren  = iREN[m_core];
      e_addr = iaddr[m_core];
    end
    chk("cyc ramREN", ramREN, e_ren);
    chk("cyc ramWEN", ramWEN, e_wen);
    if (e_ren || e_wen) chk("cyc ramaddr", ramaddr, e_addr);
    if (e_wen) chk("cyc ramstore", ramstore, e_store);
    for (int c = 0; c < 2; c++) begin
      bit own_i, own_d;
      own_i = m_own && !m_isd && (m_core == c[0]);
      own_d = m_own && m_isd && (m_core == c[0]);
      chk("cyc iwait", iwait[c], own_i ? (ramstate != ACCESS) : 1'b1);
      chk("cyc dwait", dwait[c], own_d ? (ramstate != ACCESS) : 1'b1);
      chk("cyc iload", iload[c], own_i ? ramload : 32'h0);
      chk("cyc dload", dload[c], own_d ? ramload : 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    int gseq [4];
    bit prev_ren, nxt0, nxt1;

    nRST     = 1'b0;
    ramstate = FREE;
    ramload  = '0;
    for (int c = 0; c < 2; c++) begin
      iREN[c] = 0; dREN[c] = 0; dWEN[c] = 0;
      iaddr[c] = '0; daddr[c] = '0; dstore[c] = '0;
    end
    #3;
    chk("rst ramREN", ramREN, 0);
    chk("rst ramWEN", ramWEN, 0);
    chk("rst ramaddr", ramaddr, 0);
    chk("rst iwait0", iwait[0], 1);
    chk("rst dwait1", dwait[1], 1);
    chk("rst dload0", dload[0], 0);
    #9 nRST = 1'b1;

    // single icache read with two BUSY cycles before ACCESS
    tick();
    iREN[0] = 1; iaddr[0] = 32'h40; ramstate = BUSY;
    #1 chk("t1 idle ramREN", ramREN, 0);
    tick();
    #1 chk("t1 c1 ramREN", ramREN, 1);
    chk("t1 c1 ramaddr", ramaddr, 32'h40);
    chk("t1 c1 iwait0", iwait[0], 1);
    tick();
    #1 chk("t1 c2 iwait0", iwait[0], 1);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1 chk("t1 c3 iwait0", iwait[0], 0);
    chk("t1 c3 iload0", iload[0], 32'hDEADBEEF);
    chk("t1 c3 iload1", iload[1], 0);
    tick();
    iREN[0] = 0; ramstate = FREE;
    #1 chk("t1 rel ramREN", ramREN, 0);
    tick();
    #1 chk("t1 idle iwait0", iwait[0], 1);
    chk("t1 model rr", m_rr, 1);

    // icache0 and dcache1 together: dcache first, one bubble, then icache
    iREN[0] = 1; iaddr[0] = 32'h44; dREN[1] = 1; daddr[1] = 32'h200;
    ramstate = ACCESS; ramload = 32'h12345678;
    tick();
    #1 chk("t2 d1 ramaddr", ramaddr, 32'h200);
    chk("t2 d1 ramREN", ramREN, 1);
    chk("t2 d1 dwait1", dwait[1], 0);
    chk("t2 d1 dload1", dload[1], 32'h12345678);
    chk("t2 d1 iwait0", iwait[0], 1);
    tick();
    dREN[1] = 0;
    #1 chk("t2 rel ramREN", ramREN, 0);
    tick();
    #1 chk("t2 bubble ramREN", ramREN, 0);
    chk("t2 bubble iwait0", iwait[0], 1);
    tick();
    #1 chk("t2 i0 ramaddr", ramaddr, 32'h44);
    chk("t2 i0 ramREN", ramREN, 1);
    chk("t2 i0 iwait0", iwait[0], 0);
    tick();
    iREN[0] = 0;
    tick();

    // two-word writeback from dcache0 while icache1 waits
    dWEN[0] = 1; dREN[0] = 1; daddr[0] = 32'h100; dstore[0] = 32'h11111111;
    iREN[1] = 1; iaddr[1] = 32'h80;
    tick();
    #1 chk("t3 w0 ramWEN", ramWEN, 1);
    chk("t3 w0 ramREN", ramREN, 0);
    chk("t3 w0 ramaddr", ramaddr, 32'h100);
    chk("t3 w0 ramstore", ramstore, 32'h11111111);
    chk("t3 w0 dwait0", dwait[0], 0);
    tick();
    dREN[0] = 0; daddr[0] = 32'h104; dstore[0] = 32'h22222222;
    #1 chk("t3 w1 ramWEN", ramWEN, 1);
    chk("t3 w1 ramaddr", ramaddr, 32'h104);
    chk("t3 w1 ramstore", ramstore, 32'h22222222);
    chk("t3 w1 iwait1", iwait[1], 1);
    tick();
    dWEN[0] = 0;
    #1 chk("t3 rel ramWEN", ramWEN, 0);
    tick();
    #1 chk("t3 bubble ramREN", ramREN, 0);
    tick();
    #1 chk("t3 i1 ramREN", ramREN, 1);
    chk("t3 i1 ramaddr", ramaddr, 32'h80);
    chk("t3 i1 iwait1", iwait[1], 0);
    tick();
    iREN[1] = 0;
    tick();
    chk("t3 model rr", m_rr, 0);

    // both dcaches re-requesting: grants must alternate
    daddr[0] = 32'h300; daddr[1] = 32'h400; dREN[0] = 1; dREN[1] = 1;
    ng = 0;
    prev_ren = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      #1;
      if (ramREN && !prev_ren) begin
        gseq[ng] = (ramaddr == 32'h400) ? 1 : 0;
        ng++;
      end
      prev_ren = ramREN;
      nxt0 = dREN[0] ? dwait[0] : 1'b1;
      nxt1 = dREN[1] ? dwait[1] : 1'b1;
      tick();
      dREN[0] = nxt0;
      dREN[1] = nxt1;
    end
    chk("t4 grant count", ng, 4);
    for (int k = 0; k < 4 && k < ng; k++) chk("t4 grant order", gseq[k], k % 2);
    dREN[0] = 0; dREN[1] = 0;
    tick();
    tick();
    tick();

    // ERROR for five cycles holds the grant with wait high
    iREN[0] = 1; iaddr[0] = 32'h500; ramstate = ERROR;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1 chk("t5 err iwait0", iwait[0], 1);
      chk("t5 err ramREN", ramREN, 1);
      chk("t5 err ramaddr", ramaddr, 32'h500);
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    #1 chk("t5 acc iwait0", iwait[0], 0);
    chk("t5 acc iload0", iload[0], 32'hCAFEF00D);
    tick();
    iREN[0] = 0;
    tick();
    tick();

    // reset in the middle of a dcache1 write
    dWEN[1] = 1; daddr[1] = 32'h600; dstore[1] = 32'h0000ABCD; ramstate = BUSY;
    tick();
    #1 chk("t6 pre ramWEN", ramWEN, 1);
    #1 nRST = 1'b0;
    #1 chk("t6 rst ramWEN", ramWEN, 0);
    chk("t6 rst ramREN", ramREN, 0);
    chk("t6 rst dwait1", dwait[1], 1);
    dWEN[1] = 0;
    tick();
    nRST = 1'b1;
    dREN[0] = 1; dREN[1] = 1; daddr[0] = 32'h700; daddr[1] = 32'h800; ramstate = ACCESS;
    #1 chk("t6 post ramREN", ramREN, 0);
    chk("t6 post ramWEN", ramWEN, 0);
    tick();
    #1 chk("t6 rr0 ramaddr", ramaddr, 32'h700);
    chk("t6 rr0 ramREN", ramREN, 1);
    dREN[0] = 0; dREN[1] = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
